// File: rtl/ab_cond_pkg.sv
// Shared types and constants for the A/B input conditioner.
package ab_cond_pkg;

  typedef enum logic [1:0] {
    LO       = 2'b00,
    RISE_CHK = 2'b01,
    HI       = 2'b10,
    FALL_CHK = 2'b11
  } cond_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/ab_cond_chan.sv
// One conditioner channel: two-flop synchroniser, stability-count debounce, rising-edge pulse.
// Optional debounced level output when AB_COND_LEVEL_OUT_EN is defined.
module ab_cond_chan
  import ab_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
`ifdef AB_COND_LEVEL_OUT_EN
  ,
  output logic level
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s2;
  cond_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;

  assign s2 = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= LO;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      LO: begin
        if (s2) begin
          state_d = RISE_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      RISE_CHK: begin
        if (!s2) begin
          state_d = LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HI;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HI: begin
        if (!s2) begin
          state_d = FALL_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      FALL_CHK: begin
        if (s2) begin
          state_d = HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign pulse = pulse_q;

`ifdef AB_COND_LEVEL_OUT_EN
  // Debounced level is high from acceptance of a rise until a fall is accepted.
  assign level = (state_q == HI) || (state_q == FALL_CHK);
`endif

endmodule

// File: rtl/ab_input_conditioner.sv
// Two independent conditioner channels producing A/B event pulses for the sequence detector.
// Define AB_COND_LEVEL_OUT_EN to add debounced a_level/b_level outputs.
module ab_input_conditioner
  import ab_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_a,
  input  logic raw_b,
  output logic a_pulse,
  output logic b_pulse
`ifdef AB_COND_LEVEL_OUT_EN
  ,
  output logic a_level,
  output logic b_level
`endif
);

  ab_cond_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_a (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (raw_a),
    .pulse  (a_pulse)
`ifdef AB_COND_LEVEL_OUT_EN
    ,
    .level  (a_level)
`endif
  );

  ab_cond_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_b (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (raw_b),
    .pulse  (b_pulse)
`ifdef AB_COND_LEVEL_OUT_EN
    ,
    .level  (b_level)
`endif
  );

endmodule

// File: tb/tb_ab_input_conditioner.sv
// Self-checking bench: constant vector table, hand-written corner sequences and a
// run-length reference model driven by random stimulus.
module tb_ab_input_conditioner;

  localparam int unsigned DEB = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic raw_a, raw_b;
  logic a_pulse, b_pulse;
`ifdef AB_COND_LEVEL_OUT_EN
  logic a_level, b_level;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ab_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .a_pulse(a_pulse),
    .b_pulse(b_pulse)
`ifdef AB_COND_LEVEL_OUT_EN
    ,
    .a_level(a_level),
    .b_level(b_level)
`endif
  );

  // Reference model per channel: raw history (2-edge sync delay), debounced level,
  // and length of the current run of samples disagreeing with that level.
  logic hist0 [2];
  logic hist1 [2];
  logic mlev  [2];
  int   mrun  [2];
  logic mpul  [2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      hist0[c] = 1'b0; hist1[c] = 1'b0; mlev[c] = 1'b0; mrun[c] = 0; mpul[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic a, input logic b);
    logic r [2];
    logic v;
    r[0] = a; r[1] = b;
    for (int c = 0; c < 2; c++) begin
      v = hist1[c];
      mpul[c] = 1'b0;
      if (v != mlev[c]) begin
        mrun[c]++;
        if (mrun[c] == DEB) begin
          mlev[c] = v;
          mrun[c] = 0;
          mpul[c] = v;
        end
      end else begin
        mrun[c] = 0;
      end
      hist1[c] = hist0[c];
      hist0[c] = r[c];
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive at negedge, take one posedge, then return at the following negedge.
  task automatic tick(input logic a, input logic b);
    raw_a = a;
    raw_b = b;
    @(posedge clk);
    if (reset_n) model_edge(a, b);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, " a_pulse"}, a_pulse, mpul[0]);
    check({tag, " b_pulse"}, b_pulse, mpul[1]);
`ifdef AB_COND_LEVEL_OUT_EN
    check({tag, " a_level"}, a_level, mlev[0]);
    check({tag, " b_level"}, b_level, mlev[1]);
`endif
  endtask

  typedef struct {
    logic a;
    logic b;
    logic ea;
    logic eb;
  } vec_t;

  vec_t vecs[$];

  task automatic push(input logic a, input logic b, input logic ea, input logic eb);
    vec_t v;
    v.a = a; v.b = b; v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endtask

  int npa, npb;
  logic ra, rb;

  initial begin
    raw_a   = 1'b1;
    raw_b   = 1'b1;
    reset_n = 1'b0;
    model_reset();

    // Reset held with inputs high: no pulses.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_hold a_pulse", a_pulse, 1'b0);
      check("reset_hold b_pulse", b_pulse, 1'b0);
    end
    // Release before edge 1 with raw_a high: a_pulse only after edge 6.
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b0);
      check($sformatf("reset_rel a_pulse e%0d", i), a_pulse, i == 6);
      check($sformatf("reset_rel b_pulse e%0d", i), b_pulse, 1'b0);
    end
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

    // Constant vector table; entries index from edge 1 of each segment.
    for (int i = 0; i < 12; i++) push(1'b1, 1'b0, i == 5, 1'b0);       // clean rise A
    for (int i = 0; i < 8; i++)  push(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) push(1'b1, 1'b1, i == 5, i == 5);     // simultaneous
    for (int i = 0; i < 8; i++)  push(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  push(1'b0, 1'b1, 1'b0, 1'b0);         // glitch B, 3 cycles
    for (int i = 0; i < 8; i++)  push(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)  push(1'b1, 1'b0, i == 5, 1'b0);       // A exactly DEB cycles
    for (int i = 4; i < 12; i++) push(1'b0, 1'b0, i == 5, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d a_pulse", i), a_pulse, vecs[i].ea);
      check($sformatf("vec%0d b_pulse", i), b_pulse, vecs[i].eb);
    end
`ifdef AB_COND_LEVEL_OUT_EN
    check("glitch b_level", b_level, 1'b0);
`endif

    // Held high then bounce on fall: one pulse while held, none from the bounce.
    npa = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b1, 1'b0); check_model("held"); npa += int'(a_pulse);
    end
    check("held one pulse", npa == 1, 1'b1);
    npa = 0;
    for (int i = 0; i < 5; i++) begin
      tick(i[0], 1'b0); check_model("bounce"); npa += int'(a_pulse);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0); check_model("fall_hold"); npa += int'(a_pulse);
    end
    check("bounce no pulse", npa == 0, 1'b1);
    npa = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b0);
      check($sformatf("new_rise a_pulse e%0d", i), a_pulse, i == 6);
      npa += int'(a_pulse);
    end
    check("new rise one pulse", npa == 1, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

    // Mid-operation reset while in rise check: count aborted, restart from scratch.
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, 1'b0);
      check("pre_reset a_pulse", a_pulse, 1'b0);
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async reset a_pulse", a_pulse, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      check("in_reset a_pulse", a_pulse, 1'b0);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b0);
      check($sformatf("post_reset a_pulse e%0d", i), a_pulse, i == 6);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0); check_model("settle");
    end

    // Random runs of varied length compared against the model.
    ra = 1'b0; rb = 1'b0; npa = 0; npb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) ra = ~ra;
      if ($urandom_range(0, 4) == 0) rb = ~rb;
      tick(ra, rb);
      check_model("rand");
      npa += int'(a_pulse);
      npb += int'(b_pulse);
    end
    check("rand saw a pulses", npa > 0, 1'b1);
    check("rand saw b pulses", npb > 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
